// File: rtl/bcd_display_scanner_if.sv
// Bus between the BCD multiplier and the display scanner.
// The multiplier side drives the result and its done flag.
// The scanner side drives the multiplexed 7-segment display.
interface bcd_display_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  finish;
  logic [DIGITS*4-1:0]   bcd;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  valid;

  modport master (output finish, output bcd, input seg, input an, input valid);
  modport slave  (input finish, input bcd, output seg, output an, output valid);
endinterface

// File: rtl/bcd_display_scanner.sv
// Captures a packed BCD product on the rising edge of the multiplier's finish
// flag and scans it onto a time-multiplexed 7-segment display, one digit per
// PRESCALE cycles. Leading zeros are blanked; nibbles above 9 display as 'E'.
module bcd_display_scanner #(
  parameter int N        = 5,
  parameter int DIGITS   = ((2*N)/3)+1,
  parameter int PRESCALE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_display_scanner_if.slave    bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DIGITS*4-1:0] cap_q, cap_d;
  logic                finish_dly_q, finish_dly_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [3:0]          nib   [DIGITS];
  logic [DIGITS-1:0]   blank;
  logic                finish_rise;

  // Split the captured word into nibbles and work out which digits are
  // leading zeros (this digit and every more significant one are zero).
  // Digit 0 always shows so that a zero result reads "0".
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi] = cap_q[gi*4 +: 4];
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = ~|cap_q[DIGITS*4-1:gi*4];
      end
    end
  endgenerate

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h79;
    endcase
  endfunction

  assign finish_rise = bus.finish & ~finish_dly_q;

  // Next-state: capture on finish rise, free-running scan counters, and
  // registered display drive computed from the current digit and capture.
  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    finish_dly_d = bus.finish;
    pcnt_d       = pcnt_q + PW'(1);
    idx_d        = idx_q;
    seg_d        = 7'h00;
    an_d         = '0;

    if (finish_rise) begin
      cap_d   = bus.bcd;
      state_d = ST_SHOW;
    end

    if (pcnt_q == PW'(PRESCALE-1)) begin
      pcnt_d = '0;
      idx_d  = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + IW'(1);
    end

    if ((state_q == ST_SHOW) && !blank[idx_q]) begin
      an_d  = DIGITS'(1) << idx_q;
      seg_d = decode(nib[idx_q]);
    end
  end

  // State register with synchronous reset; finish is not sampled in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cap_q        <= '0;
      finish_dly_q <= 1'b0;
      pcnt_q       <= '0;
      idx_q        <= '0;
      seg_q        <= 7'h00;
      an_q         <= '0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      finish_dly_q <= finish_dly_d;
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.valid = (state_q == ST_SHOW);

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: directed scenarios followed by
// randomized traffic, all compared every cycle against a time-based model.
module tb_bcd_display_scanner;

  localparam int N        = 5;
  localparam int DIGITS   = ((2*N)/3)+1;
  localparam int PRESCALE = 4;
  localparam int BW       = DIGITS*4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bcd_display_scanner_if #(.DIGITS(DIGITS)) bus ();

  bcd_display_scanner #(
    .N(N), .DIGITS(DIGITS), .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // Model state: captured value, valid flag, last sampled finish, and the
  // number of clock edges since reset (scan position derives from it).
  logic [BW-1:0] m_cap;
  bit            m_valid;
  bit            m_fin;
  int            m_k;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, advance the model, compare after the edge.
  task automatic tick(input logic r, input logic f, input logic [BW-1:0] b);
    logic [6:0]        e_seg;
    logic [DIGITS-1:0] e_an;
    logic [31:0]       upper;
    int                idx;
    int                nib;
    reset      = r;
    bus.finish = f;
    bus.bcd    = b;
    @(posedge clk);
    e_seg = '0;
    e_an  = '0;
    if (r) begin
      m_cap   = '0;
      m_valid = 1'b0;
      m_fin   = 1'b0;
      m_k     = 0;
    end else begin
      idx   = (m_k / PRESCALE) % DIGITS;
      upper = 32'(m_cap) >> (4*idx);
      nib   = int'(upper & 32'hF);
      if (m_valid && (idx == 0 || upper != 0)) begin
        e_an  = DIGITS'(1) << idx;
        e_seg = seg_of(nib);
      end
      m_k++;
      if (f && !m_fin) begin
        m_cap   = b;
        m_valid = 1'b1;
        $display("capture bcd=%h at cycle %0d", b, cyc_n);
      end
      m_fin = f;
    end
    cyc_n++;
    #1;
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("an", 32'(bus.an), 32'(e_an));
    chk("valid", 32'(bus.valid), 32'(m_valid));
    chk("an_onehot", 32'($countones(bus.an) <= 1), 32'd1);
  endtask

  initial begin
    logic [31:0] rnd;
    logic        fin_r;
    reset      = 1'b1;
    bus.finish = 1'b0;
    bus.bcd    = '0;
    m_cap      = '0;
    m_valid    = 1'b0;
    m_fin      = 1'b0;
    m_k        = 0;

    // Reset then idle: display must stay dark.
    repeat (3) tick(1'b1, 1'b0, '0);
    repeat (40) tick(1'b0, 1'b0, '0);

    // Product 780.
    tick(1'b0, 1'b1, BW'(16'h0780));
    tick(1'b0, 1'b0, BW'(16'h0780));
    repeat (20) tick(1'b0, 1'b0, '0);

    // Product 169, then zero.
    tick(1'b0, 1'b1, BW'(16'h0169));
    repeat (20) tick(1'b0, 1'b0, BW'(16'h0169));
    tick(1'b0, 1'b1, '0);
    repeat (20) tick(1'b0, 1'b0, '0);

    // Held finish ignores bcd changes; a fresh rise recaptures.
    tick(1'b0, 1'b1, BW'(16'h0042));
    repeat (29) tick(1'b0, 1'b1, BW'(16'h0999));
    tick(1'b0, 1'b0, BW'(16'h0999));
    repeat (21) tick(1'b0, 1'b1, BW'(16'h0999));
    tick(1'b0, 1'b0, '0);

    // Invalid nibble shows 'E'.
    tick(1'b0, 1'b1, BW'(16'h00A5));
    repeat (20) tick(1'b0, 1'b0, '0);

    // Reset mid-scan while digit 1 is up, then stay dark until a new rise.
    tick(1'b0, 1'b1, BW'(16'h1234));
    for (int i = 0; i < DIGITS*PRESCALE && ((m_k / PRESCALE) % DIGITS) != 2; i++)
      tick(1'b0, 1'b0, BW'(16'h1234));
    tick(1'b1, 1'b0, BW'(16'h1234));
    repeat (20) tick(1'b0, 1'b0, BW'(16'h5678));

    // Finish rising together with reset is lost; held high afterwards
    // it reads as a new rise once reset releases.
    tick(1'b1, 1'b1, BW'(16'h9999));
    repeat (20) tick(1'b0, 1'b1, BW'(16'h0305));
    tick(1'b0, 1'b0, '0);

    // Randomized traffic with occasional resets and leading-zero results.
    fin_r = 1'b0;
    for (int i = 0; i < 500; i++) begin
      rnd = $urandom;
      rnd = rnd >> (4*$urandom_range(0, DIGITS));
      if ($urandom_range(0, 7) == 0) fin_r = ~fin_r;
      tick(($urandom_range(0, 99) == 0), fin_r, BW'(rnd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Downstream stage of the BCD multiplier. It captures the packed BCD product when the multiplier's `finish` rises and drives a common-anode-select, time-multiplexed 7-segment display, one digit at a time. Leading zeros are blanked and non-decimal nibbles are flagged. The capture register decouples the display from the multiplier, so a new multiplication can start while the previous result stays on screen.

## Interface
- `N`, 5: multiplier operand width; sizes the BCD bus to match the multiplier.
- `DIGITS`, ((2*N)/3)+1: number of BCD digits (4 for N=5).
- `PRESCALE`, 4: clock cycles each digit stays selected (≥2).

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `finish`  in  1  multiplier done flag (level; may stay high for many cycles).
- `bcd`  in  DIGITS*4  packed BCD product, digit 0 = bits [3:0] (least significant).
- `seg`  out  7  segment drive {g,f,e,d,c,b,a}, active-high.
- `an`  out  DIGITS  digit select, one-hot active-high, all-zero = dark.
- `valid`  out  1  high once a result has been captured.

## Operation
- **Capture**
  - `finish_d` registers `finish`.
  - Capture happens on the clock edge where `finish`=1 and `finish_d`=0. At that edge, `bcd` is loaded into `cap` and `valid` is set.
  - `bcd` is ignored at all other times, including while `finish` is held high.
- **Scan counters**
  - `pcnt` counts 0..PRESCALE-1.
  - When `pcnt`=PRESCALE-1, it wraps to 0 and `idx` advances. `idx` wraps from DIGITS-1 to 0.
  - Both counters run continuously after reset, regardless of `valid`.
  - A capture does not reset `pcnt` or `idx`.
- **Blanking**
  - Digit `i` (i>0) is blank if nibbles i..DIGITS-1 of `cap` are all zero.
  - Digit 0 is never blanked.
  - A nibble >9 counts as nonzero.
- **Decode**
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Any nibble 10..15 = 0x79 ('E').
- **Output registers** (next values):
  - If `valid`=0 or digit `idx` is blank: `an`=0, `seg`=0.
  - Otherwise: `an`=1<<idx, `seg`=decode(cap[idx]).
- **States (implicit)**
  - IDLE: `valid`=0, display dark.
  - SHOW: `valid`=1, scanning.
  - IDLE→SHOW on the first capture. SHOW persists until `reset`.
  - A new capture in SHOW replaces `cap` with no gap in scanning.

## Timing
- **Reset values:** `seg`=0, `an`=0, `valid`=0, `cap`=0, `finish_d`=0, `pcnt`=0, `idx`=0.
- **Reset behaviour:** while `reset` is high, all registers hold reset values and `finish` is not sampled. A rising `finish` in the same cycle as `reset` is lost.
- **Capture latency:** `valid` rises on edge E (the capture edge). `seg`/`an` reflect the new `cap` starting at edge E+1.
- **Output timing:** `seg`/`an` at edge t+1 reflect `idx`, `cap` and `valid` as they were after edge t. Each digit is selected for exactly PRESCALE consecutive cycles.
- **Scan period:** full refresh is DIGITS*PRESCALE cycles (16 at defaults).
- **Glitch-free outputs:** `an` is never multi-hot. `an` and `seg` change on the same edge.
- **Reset mid-scan:** the next edge clears everything. No display until a new `finish` rising edge after `reset` is released.

## Test plan
1. **Reset, no finish:** hold `reset` 3 cycles, release, keep `finish`=0 for 40 cycles → `valid`=0, `an`=0, `seg`=0 throughout.
2. **Product 780 (26×30):** `bcd`=0x0780, pulse `finish` → `valid`=1 next edge; each digit held 4 cycles in order:
   - digit 0: `an`=0001, `seg`=0x3F
   - digit 1: `an`=0010, `seg`=0x7F
   - digit 2: `an`=0100, `seg`=0x07
   - digit 3: `an`=0000, `seg`=0x00 (blanked)
3. **Product 169 (13×13), then zero:** `bcd`=0x0169, rise `finish` → digits show 0x6F, 0x7D, 0x06, then digit 3 blank. Then capture `bcd`=0x0000 → only digit 0 lit (0x3F); digits 1–3 dark.
4. **Held finish:** raise `finish` with `bcd`=0x0042, hold it 30 cycles while changing `bcd` to 0x0999 → display stays 2, 4, blank, blank. Drop then re-raise `finish` → 9, 9, 9, blank appears from the following edge.
5. **Invalid nibble:** capture `bcd`=0x00A5 → digit 0 `seg`=0x6D, digit 1 `seg`=0x79, digits 2–3 blank.
6. **Reset mid-scan:** assert `reset` one cycle while digit 1 is selected → next edge all outputs 0 and `valid`=0. After release, display stays dark until a new `finish` rise.
